// File: rtl/game_phase_sequencer.sv
// rtl/game_phase_sequencer.sv - round controller: prelim/game sequencing, level scoring, digit mux
// Clk1Hz is resynchronised locally; all state advances on Clk100M.
module game_phase_sequencer #(
  parameter int GAME_SECONDS = 30,
  parameter int PASS_SCORE   = 5,
  parameter int MAX_LEVEL    = 9
) (
  input  logic       Clk100M,
  input  logic       Rst_n,
  input  logic       Clk1Hz,
  input  logic       startBtn,
  input  logic       gameSig,
  input  logic       roundDone,
  input  logic [7:0] roundScore,
  input  logic [7:0] prelimSeg0,
  input  logic [7:0] prelimSeg1,
  input  logic [7:0] prelimSeg2,
  input  logic [7:0] prelimSeg3,
  input  logic [7:0] gameSeg0,
  input  logic [7:0] gameSeg1,
  input  logic [7:0] gameSeg2,
  input  logic [7:0] gameSeg3,
  output logic       prelimSig,
  output logic       gameActive,
  output logic [3:0] curLevel,
  output logic [6:0] timeLeft,
  output logic [2:0] phase,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] seg2,
  output logic [7:0] seg3
);

  localparam logic [6:0] GAME_SECS = 7'(GAME_SECONDS);
  localparam logic [7:0] PASS_MIN  = 8'(PASS_SCORE);
  localparam logic [3:0] LAST_LVL  = 4'(MAX_LEVEL);
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_U     = 8'hC1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PSTART = 3'd1,
    S_PWAIT  = 3'd2,
    S_GAME   = 3'd3,
    S_EVAL   = 3'd4,
    S_LOSE   = 3'd5,
    S_WIN    = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [6:0] time_q, time_d;
  logic [7:0] score_q, score_d;
  logic       sync1_q, sync2_q, edge_q;
  logic [7:0] seg0_q, seg1_q, seg2_q, seg3_q;
  logic [7:0] seg0_d, seg1_d, seg2_d, seg3_d;
  logic       tick;

  // One-cycle pulse on the synchronised rising edge of the seconds clock.
  assign tick = sync2_q & ~edge_q;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    time_d  = time_q;
    score_d = score_q;
    case (state_q)
      S_IDLE: begin
        if (startBtn) state_d = S_PSTART;
      end
      S_PSTART: state_d = S_PWAIT;
      S_PWAIT: begin
        if (gameSig) begin
          state_d = S_GAME;
          time_d  = GAME_SECS;
        end
      end
      S_GAME: begin
        if (tick && (time_q != 7'd0)) time_d = time_q - 7'd1;
        if ((tick && (time_q <= 7'd1)) || roundDone) begin
          state_d = S_EVAL;
          score_d = roundScore;
        end
      end
      S_EVAL: begin
        if (score_q >= PASS_MIN) begin
          if (level_q >= LAST_LVL) begin
            state_d = S_WIN;
          end else begin
            state_d = S_PSTART;
            level_d = level_q + 4'd1;
          end
        end else begin
          state_d = S_LOSE;
        end
      end
      S_LOSE, S_WIN: begin
        if (startBtn) begin
          state_d = S_PSTART;
          level_d = 4'd1;
          score_d = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    seg0_d = SEG_BLANK;
    seg1_d = SEG_BLANK;
    seg2_d = SEG_BLANK;
    seg3_d = SEG_BLANK;
    case (state_q)
      S_PSTART, S_PWAIT: begin
        seg0_d = prelimSeg0;
        seg1_d = prelimSeg1;
        seg2_d = prelimSeg2;
        seg3_d = prelimSeg3;
      end
      S_GAME, S_EVAL: begin
        seg0_d = gameSeg0;
        seg1_d = gameSeg1;
        seg2_d = gameSeg2;
        seg3_d = gameSeg3;
      end
      S_LOSE: begin
        seg0_d = SEG_L;
        seg1_d = SEG_L;
        seg2_d = SEG_L;
        seg3_d = SEG_L;
      end
      S_WIN: begin
        seg0_d = SEG_U;
        seg1_d = SEG_U;
        seg2_d = SEG_U;
        seg3_d = SEG_U;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      level_q <= 4'd1;
      time_q  <= GAME_SECS;
      score_q <= 8'd0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      seg0_q  <= SEG_BLANK;
      seg1_q  <= SEG_BLANK;
      seg2_q  <= SEG_BLANK;
      seg3_q  <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      time_q  <= time_d;
      score_q <= score_d;
      sync1_q <= Clk1Hz;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      seg0_q  <= seg0_d;
      seg1_q  <= seg1_d;
      seg2_q  <= seg2_d;
      seg3_q  <= seg3_d;
    end
  end

  // Decoded from the state register so a reset cuts a prelim pulse short at once.
  assign prelimSig  = (state_q == S_PSTART);
  assign gameActive = (state_q == S_GAME);
  assign phase      = state_q;
  assign curLevel   = level_q;
  assign timeLeft   = time_q;
  assign seg0       = seg0_q;
  assign seg1       = seg1_q;
  assign seg2       = seg2_q;
  assign seg3       = seg3_q;

endmodule

// File: tb/tb_game_phase_sequencer.sv
// tb/tb_game_phase_sequencer.sv - randomized round-level bench for game_phase_sequencer
module tb_game_phase_sequencer;
  localparam int GS = 3;
  localparam int PS = 5;
  localparam int ML = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk1hz = 1'b0;
  logic       start_btn = 1'b0;
  logic       game_sig = 1'b0;
  logic       round_done = 1'b0;
  logic [7:0] round_score = 8'd0;
  logic [7:0] pseg0 = 8'h00, pseg1 = 8'h00, pseg2 = 8'h00, pseg3 = 8'h00;
  logic [7:0] gseg0 = 8'h00, gseg1 = 8'h00, gseg2 = 8'h00, gseg3 = 8'h00;
  logic       prelim_sig, game_active;
  logic [3:0] cur_level;
  logic [6:0] time_left;
  logic [2:0] phase;
  logic [7:0] seg0, seg1, seg2, seg3;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  int eval_cnt  = 0;
  int m_level = 1;
  int m_time  = GS;

  game_phase_sequencer #(.GAME_SECONDS(GS), .PASS_SCORE(PS), .MAX_LEVEL(ML)) dut (
    .Clk100M(clk), .Rst_n(rst_n), .Clk1Hz(clk1hz),
    .startBtn(start_btn), .gameSig(game_sig), .roundDone(round_done),
    .roundScore(round_score),
    .prelimSeg0(pseg0), .prelimSeg1(pseg1), .prelimSeg2(pseg2), .prelimSeg3(pseg3),
    .gameSeg0(gseg0), .gameSeg1(gseg1), .gameSeg2(gseg2), .gameSeg3(gseg3),
    .prelimSig(prelim_sig), .gameActive(game_active), .curLevel(cur_level),
    .timeLeft(time_left), .phase(phase),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prelim_sig) pulse_cnt++;
    if (phase == 3'd4) eval_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_segs(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, "_seg0"}, int'(seg0), e0);
    check({tag, "_seg1"}, int'(seg1), e1);
    check({tag, "_seg2"}, int'(seg2), e2);
    check({tag, "_seg3"}, int'(seg3), e3);
  endtask

  task automatic new_sources();
    pseg0 = 8'($urandom); pseg1 = 8'($urandom); pseg2 = 8'($urandom); pseg3 = 8'($urandom);
    gseg0 = 8'($urandom); gseg1 = 8'($urandom); gseg2 = 8'($urandom); gseg3 = 8'($urandom);
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    m_level = 1;
    check("start_phase", int'(phase), 1);
    check("start_prelim", int'(prelim_sig), 1);
    check("start_level", int'(cur_level), 1);
  endtask

  task automatic tick_full();
    clk1hz = 1'b1;
    step(6);
    m_time--;
    check("tick_time", int'(time_left), m_time);
    check("tick_phase", int'(phase), 3);
    clk1hz = 1'b0;
    step(6);
  endtask

  task automatic finish_exit(input int score, input int e0, input int p0);
    int b;
    b = 0;
    while ((phase == 3'd3 || phase == 3'd4) && b < 16) begin
      step();
      b++;
    end
    check("exit_in_time", int'(b < 16), 1);
    check("eval_once", eval_cnt - e0, 1);
    check("exit_active", int'(game_active), 0);
    if (score >= PS) begin
      if (m_level == ML) begin
        check("exit_win", int'(phase), 6);
        check("win_level", int'(cur_level), m_level);
        step();
        check_segs("win", 8'hC1, 8'hC1, 8'hC1, 8'hC1);
      end else begin
        m_level++;
        check("exit_next", int'(phase), 1);
        check("next_prelim", int'(prelim_sig), 1);
        check("next_pulses", pulse_cnt - p0, 1);
        check("next_level", int'(cur_level), m_level);
      end
    end else begin
      check("exit_lose", int'(phase), 5);
      step();
      check_segs("lose", 8'hC7, 8'hC7, 8'hC7, 8'hC7);
    end
  endtask

  // Entered at the cycle where the sequencer sits in PSTART.
  task automatic play_round(input int mode, input int k, input int score);
    int p0;
    int e0;
    p0 = pulse_cnt;
    new_sources();
    step();
    check("pwait_phase", int'(phase), 2);
    check("pwait_prelim", int'(prelim_sig), 0);
    check_segs("prelim", pseg0, pseg1, pseg2, pseg3);
    step($urandom_range(1, 8));
    check("pwait_hold", int'(phase), 2);
    game_sig = 1'b1;
    step();
    game_sig = 1'b0;
    m_time = GS;
    check("game_phase", int'(phase), 3);
    check("game_active", int'(game_active), 1);
    check("game_time", int'(time_left), GS);
    check("one_pulse", pulse_cnt - p0, 0);
    round_score = 8'(score);
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    check("game_ignore_start", int'(phase), 3);
    check_segs("game", gseg0, gseg1, gseg2, gseg3);
    e0 = eval_cnt;
    p0 = pulse_cnt;
    if (mode == 0) begin
      repeat (k) tick_full();
      round_done = 1'b1;
      step();
      round_done = 1'b0;
      finish_exit(score, e0, p0);
    end else if (mode == 1) begin
      repeat (GS - 1) tick_full();
      clk1hz = 1'b1;
      finish_exit(score, e0, p0);
      clk1hz = 1'b0;
    end else begin
      repeat (GS - 1) tick_full();
      clk1hz = 1'b1;
      step(2);
      round_done = 1'b1;
      step();
      round_done = 1'b0;
      finish_exit(score, e0, p0);
      clk1hz = 1'b0;
    end
  endtask

  initial begin
    new_sources();
    step(2);
    check("rst_phase", int'(phase), 0);
    check("rst_level", int'(cur_level), 1);
    check("rst_prelim", int'(prelim_sig), 0);
    check("rst_active", int'(game_active), 0);
    check("rst_time", int'(time_left), GS);
    check_segs("rst", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    rst_n = 1'b1;
    step();

    game_sig = 1'b1;
    round_done = 1'b1;
    step();
    round_done = 1'b0;
    step(4);
    check("idle_ignore", int'(phase), 0);
    check("idle_blank", int'(seg0), 8'hFF);
    game_sig = 1'b0;
    step();

    press_start();
    play_round(0, 1, PS);
    play_round(2, 0, 7);
    press_start();
    play_round(1, 0, PS - 1);

    for (int r = 0; r < 12; r++) begin
      if (phase != 3'd1) press_start();
      play_round(int'($urandom_range(0, 2)), int'($urandom_range(0, GS - 2)),
                 int'($urandom_range(0, 9)));
    end

    if (phase != 3'd1) press_start();
    step();
    game_sig = 1'b1;
    step();
    game_sig = 1'b0;
    check("pre_rst_game", int'(phase), 3);
    rst_n = 1'b0;
    #1;
    check("midgame_rst_phase", int'(phase), 0);
    check("midgame_rst_level", int'(cur_level), 1);
    check("midgame_rst_active", int'(game_active), 0);
    check("midgame_rst_seg", int'(seg0), 8'hFF);
    step();
    rst_n = 1'b1;
    step();

    press_start();
    play_round(0, 0, 9);
    rst_n = 1'b0;
    #1;
    check("pstart_rst_prelim", int'(prelim_sig), 0);
    check("pstart_rst_level", int'(cur_level), 1);
    check("pstart_rst_phase", int'(phase), 0);
    step();
    rst_n = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
